// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply / divide unit for the execute stage.
// Multiply is a signed shift-add over ITER cycles. Divide is restoring division on
// magnitudes followed by a sign fix, with the quotient truncated toward zero.
// Optional feature: define MULTDIV_FLUSH_EN to add the i_flush abort input.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [31:0]      i_insn,
`ifdef MULTDIV_FLUSH_EN
    input  logic             i_flush,
`endif
    output logic             o_busy,
    output logic [WIDTH-1:0] o_MD_O,
    output logic [31:0]      o_MD_insn,
    output logic             o_MD_rdy,
    output logic             o_MD_exc
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;   // sign-extended multiplicand, shifted left
    logic [WIDTH-1:0]    mplier_q, mplier_d; // multiplier, shifted right
    logic [2*WIDTH-1:0]  acc_q, acc_d;       // product accumulator
    logic [WIDTH-1:0]    rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]    quo_q, quo_d;       // dividend magnitude shifting into quotient
    logic [WIDTH-1:0]    dvs_q, dvs_d;       // divisor magnitude
    logic                neg_q, neg_d;       // quotient must be negated
    logic                ovf_q, ovf_d;       // most-negative / -1 overflow
    logic [31:0]         insn_q, insn_d;
    logic                busy_q, busy_d;
    logic                rdy_q, rdy_d;
    logic [WIDTH-1:0]    md_o_q, md_o_d;
    logic [31:0]         md_insn_q, md_insn_d;
    logic                md_exc_q, md_exc_d;

    logic                flush_s;
    logic                last_s;
    logic                start_ok_s;
    logic [2*WIDTH-1:0]  mul_add_s;
    logic [2*WIDTH-1:0]  mul_acc_s;
    logic                mul_exc_s;
    logic [WIDTH:0]      rem_sh_s;
    logic                div_ge_s;
    logic [WIDTH-1:0]    div_diff_s;
    logic [WIDTH-1:0]    rem_nx_s;
    logic [WIDTH-1:0]    quo_nx_s;
    logic [WIDTH-1:0]    quo_fix_s;
    logic [WIDTH-1:0]    a_mag_s;
    logic [WIDTH-1:0]    b_mag_s;

`ifdef MULTDIV_FLUSH_EN
    assign flush_s = i_flush;
`else
    assign flush_s = 1'b0;
`endif

    // Magnitude of a two's-complement value; the most negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One iteration of both datapaths, evaluated from the current registers.
    always_comb begin
        last_s     = (cnt_q == CW'(ITER - 1));
        start_ok_s = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
        a_mag_s    = mag(i_A);
        b_mag_s    = mag(i_B);
        // Shift-add: the last (sign) bit of the multiplier carries negative weight.
        mul_add_s  = mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}};
        if (last_s) begin
            mul_acc_s = acc_q - mul_add_s;
        end else begin
            mul_acc_s = acc_q + mul_add_s;
        end
        mul_exc_s  = (mul_acc_s[2*WIDTH-1:WIDTH] != {WIDTH{mul_acc_s[WIDTH-1]}});
        // Restoring step: shift the next dividend bit into the remainder and try a subtract.
        rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
        div_ge_s   = (rem_sh_s >= {1'b0, dvs_q});
        // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
        div_diff_s = rem_sh_s[WIDTH-1:0] - dvs_q;
        if (div_ge_s) begin
            rem_nx_s = div_diff_s;
        end else begin
            rem_nx_s = rem_sh_s[WIDTH-1:0];
        end
        quo_nx_s   = {quo_q[WIDTH-2:0], div_ge_s};
        if (neg_q) begin
            quo_fix_s = (~quo_nx_s) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            quo_fix_s = quo_nx_s;
        end
    end

    // Next-state, operand latch and result capture logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        insn_d    = insn_q;
        md_o_d    = md_o_q;
        md_insn_d = md_insn_q;
        md_exc_d  = md_exc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    cnt_d    = {CW{1'b0}};
                    mcand_d  = {{WIDTH{i_A[WIDTH-1]}}, i_A};
                    mplier_d = i_B;
                    acc_d    = {(2*WIDTH){1'b0}};
                    rem_d    = {WIDTH{1'b0}};
                    quo_d    = a_mag_s;
                    dvs_d    = b_mag_s;
                    neg_d    = i_A[WIDTH-1] ^ i_B[WIDTH-1];
                    ovf_d    = (i_A == {1'b1, {(WIDTH-1){1'b0}}}) && (i_B == {WIDTH{1'b1}});
                    insn_d   = i_insn;
                    if (!i_op) begin
                        state_d = S_MUL;
                    end else if (i_B == {WIDTH{1'b0}}) begin
                        // Divide by zero completes immediately without iterating.
                        state_d   = S_DONE;
                        md_o_d    = {WIDTH{1'b0}};
                        md_insn_d = i_insn;
                        md_exc_d  = 1'b1;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    acc_d    = mul_acc_s;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    if (last_s) begin
                        state_d   = S_DONE;
                        cnt_d     = {CW{1'b0}};
                        md_o_d    = mul_acc_s[WIDTH-1:0];
                        md_insn_d = insn_q;
                        md_exc_d  = mul_exc_s;
                    end else begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_DIV: begin
                if (flush_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    if (last_s) begin
                        state_d   = S_DONE;
                        cnt_d     = {CW{1'b0}};
                        md_o_d    = quo_fix_s;
                        md_insn_d = insn_q;
                        md_exc_d  = ovf_q;
                    end else begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        rdy_d  = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            mcand_q   <= {(2*WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            insn_q    <= 32'd0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            md_o_q    <= {WIDTH{1'b0}};
            md_insn_q <= 32'd0;
            md_exc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            insn_q    <= insn_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            md_o_q    <= md_o_d;
            md_insn_q <= md_insn_d;
            md_exc_q  <= md_exc_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_MD_rdy  = rdy_q;
    assign o_MD_O    = md_o_q;
    assign o_MD_insn = md_insn_q;
    assign o_MD_exc  = md_exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: expected results are queued when an operation
// is issued and popped when the ready strobe appears. Build with MULTDIV_FLUSH_EN to
// also exercise the flush input.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        i_start;
    logic        i_op;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic [31:0] i_insn;
    logic        i_flush;
    logic        o_busy;
    logic [31:0] o_MD_O;
    logic [31:0] o_MD_insn;
    logic        o_MD_rdy;
    logic        o_MD_exc;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] insn;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = 32'd0;

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_A       (i_A),
        .i_B       (i_B),
        .i_insn    (i_insn),
`ifdef MULTDIV_FLUSH_EN
        .i_flush   (i_flush),
`endif
        .o_busy    (o_busy),
        .o_MD_O    (o_MD_O),
        .o_MD_insn (o_MD_insn),
        .o_MD_rdy  (o_MD_rdy),
        .o_MD_exc  (o_MD_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model built on native 64-bit signed arithmetic.
    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] insn);
        exp_t   e;
        longint p;
        e.insn = insn;
        if (!op) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else begin
            p     = longint'($signed(a)) / longint'($signed(b));
            e.res = p[31:0];
            e.exc = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one start for a single edge and queue its expected result.
    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] insn);
        sb_q.push_back(model(op, a, b, insn));
        i_start = 1'b1;
        i_op    = op;
        i_A     = a;
        i_B     = b;
        i_insn  = insn;
        tick();
        i_start = 1'b0;
        i_A     = $urandom;
        i_B     = $urandom;
        i_insn  = $urandom;
    endtask

    // Wait (bounded) for the ready strobe, then compare latency, busy time and result.
    task automatic wait_result(input string name, input int lat0, input int exp_lat,
                               input int exp_busy);
        int   lat;
        int   busy_cnt;
        exp_t e;
        lat      = lat0;
        busy_cnt = 0;
        while (!o_MD_rdy && lat <= 80) begin
            busy_cnt += int'(o_busy);
            tick();
            lat++;
        end
        checks++;
        if (lat > 80) begin
            errors++;
            $display("FAIL %s timeout: no rdy within 80 cycles", name);
        end else begin
            e = sb_q.pop_front();
            last_res = e.res;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            checks++;
            if (busy_cnt !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
            end
            checks++;
            if (o_MD_O !== e.res) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", name, o_MD_O, e.res);
            end
            checks++;
            if (o_MD_insn !== e.insn) begin
                errors++;
                $display("FAIL %s insn: got %h expected %h", name, o_MD_insn, e.insn);
            end
            checks++;
            if (o_MD_exc !== e.exc) begin
                errors++;
                $display("FAIL %s exc: got %b expected %b", name, o_MD_exc, e.exc);
            end
        end
    endtask

    // Count ready strobes over n cycles; none are expected.
    task automatic expect_no_rdy(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            seen += int'(o_MD_rdy);
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL %s spurious rdy: got %0d pulses expected 0", name, seen);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        i_start = 1'b0;
        i_op    = 1'b0;
        i_A     = 32'd0;
        i_B     = 32'd0;
        i_insn  = 32'd0;
        i_flush = 1'b0;
        #2;
        checks++;
        if ({o_busy, o_MD_rdy, o_MD_exc, o_MD_O, o_MD_insn} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rdy=%b exc=%b O=%h insn=%h expected all 0",
                     o_busy, o_MD_rdy, o_MD_exc, o_MD_O, o_MD_insn);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [31:0] a;
        logic [31:0] b;
        start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'h1234_5678);
        wait_result("mul_7x-3", 1, 33, 32);
        tick();
        checks++;
        if (o_MD_rdy !== 1'b0 || o_MD_O !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_hold: got rdy=%b O=%h expected rdy=0 O=ffffffeb", o_MD_rdy, o_MD_O);
        end
        start_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'hA000_0001);
        wait_result("mul_ovf", 1, 33, 32);
        tick();
        start_op(1'b0, 32'h7FFF_FFFF, 32'd1, 32'hA000_0002);
        wait_result("mul_max", 1, 33, 32);
        tick();
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i < 2) ? ($urandom & 32'h0000_FFFF) : $urandom;
            start_op(1'b0, a, b, 32'hB000_0000 + 32'(i));
            wait_result("mul_rand", 1, 33, 32);
            tick();
        end
    endtask

    task automatic test_div();
        logic [31:0] a;
        logic [31:0] b;
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hC000_0001);
        wait_result("div_-7/2", 1, 33, 32);
        tick();
        start_op(1'b1, 32'd100, 32'd0, 32'hC000_0002);
        wait_result("div_by_zero", 1, 1, 0);
        tick();
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hC000_0003);
        wait_result("div_ovf", 1, 33, 32);
        tick();
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom >> (i * 8);
            if (b == 32'd0) b = 32'd3;
            if (i[0]) b = -b;
            start_op(1'b1, a, b, 32'hD000_0000 + 32'(i));
            wait_result("div_rand", 1, 33, 32);
            tick();
        end
    endtask

    task automatic test_ignore_start();
        start_op(1'b0, 32'd1000, 32'd3, 32'hE000_0001);
        i_start = 1'b1;
        i_op    = 1'b1;
        i_A     = 32'd55;
        i_B     = 32'd5;
        i_insn  = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) tick();
        i_start = 1'b0;
        wait_result("ignore_start", 21, 33, 12);
        tick();
    endtask

    task automatic test_back_to_back();
        start_op(1'b1, 32'd1000, 32'd7, 32'hF000_0001);
        wait_result("b2b_first", 1, 33, 32);
        start_op(1'b0, 32'hFFFF_FF00, 32'd9, 32'hF000_0002);
        wait_result("b2b_second", 1, 33, 32);
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t drop;
        start_op(1'b1, 32'd12345, 32'd17, 32'h0BAD_0001);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: got %b expected 1", o_busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_MD_rdy, o_MD_exc, o_MD_O, o_MD_insn} !== 67'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%b rdy=%b exc=%b O=%h insn=%h expected all 0",
                     o_busy, o_MD_rdy, o_MD_exc, o_MD_O, o_MD_insn);
        end
        drop = sb_q.pop_front();
        last_res = 32'd0;
        tick();
        reset = 1'b1;
        expect_no_rdy("rst_mid", 40);
    endtask

`ifdef MULTDIV_FLUSH_EN
    task automatic test_flush();
        exp_t        drop;
        logic [31:0] prev;
        start_op(1'b0, 32'd6, 32'd7, 32'h00F1_0001);
        wait_result("pre_flush", 1, 33, 32);
        tick();
        prev = last_res;
        start_op(1'b0, 32'd123, 32'd456, 32'h00F1_0002);
        for (int i = 0; i < 4; i++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_MD_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got busy=%b rdy=%b expected 0 0", o_busy, o_MD_rdy);
        end
        checks++;
        if (o_MD_O !== prev) begin
            errors++;
            $display("FAIL flush_hold: got %h expected %h", o_MD_O, prev);
        end
        drop = sb_q.pop_front();
        expect_no_rdy("flush", 40);
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore_start();
        test_back_to_back();
`ifdef MULTDIV_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage. It runs alongside the main ALU and produces the result, the tag instruction and the ready strobe that the MEM/WB latch carries to writeback (MD_O, MD_insn, MD_rdy).
- One operation in flight at a time. o_busy stalls issue of further mult/div instructions.

Parameters:
- WIDTH, 32, operand and result width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  request to start an operation; qualified by !o_busy.
- i_op  in  1  0 = mult, 1 = div.
- i_A  in  WIDTH  operand A (multiplicand / dividend).
- i_B  in  WIDTH  operand B (multiplier / divisor).
- i_insn  in  32  issuing instruction; returned unchanged with the result.
- o_busy  out  1  high while iterating.
- o_MD_O  out  WIDTH  result; held until the next accepted start.
- o_MD_insn  out  32  tag of the completed operation; held like o_MD_O.
- o_MD_rdy  out  1  one-cycle completion strobe.
- o_MD_exc  out  1  exception flag for the completed operation; valid while o_MD_rdy is high, held afterwards.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (reset=0): state IDLE, iteration counter 0; o_busy, o_MD_rdy, o_MD_exc, o_MD_O and o_MD_insn all 0. Takes effect immediately, independent of clock.
- Start acceptance: i_start sampled at an edge while state is IDLE or DONE.
  - A, B, op and insn are latched; inputs are don't-care afterwards.
  - i_start while o_busy=1 is ignored. It is not queued.
- Mult:
  - Signed shift-add over ITER cycles.
  - Start sampled at edge 0; state MUL during cycles 1..32; DONE in cycle 33.
  - o_MD_O = low 32 bits of the 64-bit signed product.
  - o_MD_exc = 1 when the high 32 bits are not the sign extension of bit 31.
- Div:
  - Restoring division on magnitudes; signs fixed afterwards. Quotient truncates toward zero; remainder is discarded.
  - Same timing as mult: DIV during cycles 1..32, DONE in cycle 33.
- Div by zero (B=0): go directly IDLE to DONE in cycle 1 with o_MD_O=0 and o_MD_exc=1. No iterations.
- Div overflow (0x80000000 / 0xFFFFFFFF): result 0x80000000, o_MD_exc=1, normal 33-cycle latency.
- o_busy = 1 exactly in MUL and DIV.
- o_MD_rdy = 1 exactly in DONE.
- DONE lasts one cycle. It goes to IDLE, or to MUL/DIV (or DONE again for div-by-zero) when i_start is sampled at that edge. Back-to-back operations therefore produce rdy pulses 33 cycles apart.
- o_MD_O, o_MD_insn and o_MD_exc are registered when DONE is entered, and remain stable until the next DONE.
- Reset mid-operation aborts it: no rdy pulse, and all outputs return to reset values.

Optional Feature:
- Macro: MULTDIV_FLUSH_EN.
- Defined:
  - Adds port i_flush (in, 1).
  - i_flush=1 at an edge while in MUL/DIV moves the state to IDLE; o_busy falls next cycle and no rdy pulse is produced.
  - o_MD_O, o_MD_insn and o_MD_exc keep their previous values.
  - i_flush in IDLE/DONE has no effect. If i_flush and i_start are sampled together in DONE, start wins.
- Undefined: no i_flush port; every accepted operation runs to completion.

Test Plan:
- Reset release, then mult 7 x -3 with insn 0x12345678 → o_busy high for 32 cycles; rdy pulse in cycle 33 with o_MD_O=0xFFFFFFEB, o_MD_insn=0x12345678, exc=0.
- Mult 0x00010000 x 0x00010000 → o_MD_O=0, exc=1. Mult 0x7FFFFFFF x 1 → 0x7FFFFFFF, exc=0.
- Div -7 / 2 → 0xFFFFFFFD. Div 100 / 0 → rdy in cycle 1, o_MD_O=0, exc=1. Div 0x80000000 / -1 → 0x80000000, exc=1.
- i_start held high during busy with different operands → ignored; result matches the first operation. A start in the DONE cycle → second rdy 33 cycles after the first.
- reset pulsed low in cycle 10 of a div → outputs 0 immediately; no rdy pulse for 40 cycles.
- With MULTDIV_FLUSH_EN: i_flush in cycle 5 of a mult → idle next cycle, no rdy, previous o_MD_O retained.
